// File: rtl/posit_defines.sv
//==============================================================================
// Module      : posit_defines (package)
// Description : Width helpers, run-length detector and saturating add shared by
//               the posit denormalisation pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package posit_defines;

  function automatic int get_denorm_scale_width(input int n, input int es);
    return $clog2((n - 1) << es) + 1;
  endfunction

  function automatic int get_denorm_frac_width(input int n, input int es);
    return (n - es - 3 > 0) ? (n - es - 3) : 1;
  endfunction

  // LOD_N: number of zeros above the leading one within v[w-1:0] (w when v is 0).
  function automatic int lod_n(input logic [63:0] v, input int w);
    int  cnt;
    logic found;
    cnt   = 0;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (i < w && !found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + 1;
      end
    end
    return cnt;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/posit_denormalize_pipe_lane.sv
//==============================================================================
// Module      : posit_denorm_lane
// Description : One posit decode lane: stage 1 takes |word| and the regime run,
//               stage 2 forms signed scale and fraction. Each stage has a load.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module posit_denorm_lane
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 32,
  parameter int POSIT_ES    = 2,
  parameter int SCALE_W     = get_denorm_scale_width(POSIT_WIDTH, POSIT_ES),
  parameter int FRAC_W      = get_denorm_frac_width(POSIT_WIDTH, POSIT_ES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load1,
  input  logic                      load2,
  input  logic [POSIT_WIDTH-1:0]    posit,
  output logic                      sign,
  output logic                      nar,
  output logic                      zero,
  output logic [SCALE_W-1:0]        scale,
  output logic [FRAC_W-1:0]         frac
);

  localparam int N        = POSIT_WIDTH;
  localparam int ES       = POSIT_ES;
  localparam int KW       = $clog2(N) + 1;
  localparam int EXP_SH   = (N - 1 - ES > 0) ? (N - 1 - ES) : 0;
  localparam int FRAC_SH  = (N - 1 - ES - FRAC_W > 0) ? (N - 1 - ES - FRAC_W) : 0;
  localparam bit HAS_FRAC = (N - ES - 3) > 0;

  typedef struct packed {
    logic                      sign;
    logic                      nar;
    logic                      zero;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         frac;
  } posit_denorm_t;

  logic          s1_sign, s1_nar, s1_zero, s1_rc;
  logic [KW-1:0] s1_k0;
  logic [N-2:0]  s1_u;

  logic [N-1:0]  neg;
  logic [N-2:0]  u_c;
  logic [N-2:0]  run_src;
  logic [KW-1:0] k0_c;

  always_comb begin
    neg     = ~posit + N'(1);
    u_c     = posit[N-1] ? neg[N-2:0] : posit[N-2:0];
    run_src = u_c[N-2] ? ~u_c : u_c;
    k0_c    = KW'(lod_n(64'(run_src), N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sign <= 1'b0;
      s1_nar  <= 1'b0;
      s1_zero <= 1'b0;
      s1_rc   <= 1'b0;
      s1_k0   <= '0;
      s1_u    <= '0;
    end else if (load1) begin
      s1_sign <= posit[N-1];
      s1_nar  <= (posit == {1'b1, {(N-1){1'b0}}});
      s1_zero <= (posit == '0);
      s1_rc   <= u_c[N-2];
      s1_k0   <= k0_c;
      s1_u    <= u_c;
    end
  end

  logic [N-2:0]  rem;
  int            k_c;
  int            exp_c;
  posit_denorm_t nxt;
  posit_denorm_t s2;

  // Shifting out the regime and its terminator leaves exponent then fraction
  // MSB-aligned; bits past the word end shift in as zero.
  always_comb begin
    rem      = s1_u << (s1_k0 + KW'(1));
    k_c      = s1_rc ? (int'(s1_k0) - 1) : -int'(s1_k0);
    exp_c    = int'(rem >> EXP_SH);
    nxt      = '0;
    nxt.sign = s1_sign;
    nxt.nar  = s1_nar;
    nxt.zero = s1_zero;
    if (!s1_nar && !s1_zero) begin
      nxt.scale = SCALE_W'((k_c <<< ES) + exp_c);
      if (HAS_FRAC) nxt.frac = FRAC_W'(rem >> FRAC_SH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        s2 <= '0;
    else if (load2) s2 <= nxt;
  end

  assign sign  = s2.sign;
  assign nar   = s2.nar;
  assign zero  = s2.zero;
  assign scale = s2.scale;
  assign frac  = s2.frac;

endmodule

`default_nettype wire

// File: rtl/posit_denormalize_pipe.sv
//==============================================================================
// Module      : posit_denormalize_pipe
// Description : N_LANES posit decoders behind one elastic two-stage handshake.
//               Define POSIT_DENORM_STATS_EN for saturating delivery counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module posit_denormalize_pipe
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 32,
  parameter int POSIT_ES    = 2,
  parameter int N_LANES     = 4,
  localparam int SCALE_W    = get_denorm_scale_width(POSIT_WIDTH, POSIT_ES),
  localparam int FRAC_W     = get_denorm_frac_width(POSIT_WIDTH, POSIT_ES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [N_LANES*POSIT_WIDTH-1:0] s_posit_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [N_LANES-1:0]             m_sign_o,
  output logic [N_LANES-1:0]             m_nar_o,
  output logic [N_LANES-1:0]             m_zero_o,
  output logic [N_LANES*SCALE_W-1:0]     m_scale_o,
  output logic [N_LANES*FRAC_W-1:0]      m_frac_o
`ifdef POSIT_DENORM_STATS_EN
  ,
  output logic [31:0]                    stat_beats_o,
  output logic [31:0]                    stat_nar_o,
  output logic [31:0]                    stat_zero_o
`endif
);

  logic v1, v2, en1, en2, load1, load2;

  assign en2       = ~v2 | m_ready_i;
  assign en1       = ~v1 | en2;
  assign s_ready_o = en1;
  assign m_valid_o = v2;
  assign load1     = en1 & s_valid_i;
  assign load2     = en2 & v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (en1) v1 <= s_valid_i;
      if (en2) v2 <= v1;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    posit_denorm_lane #(
      .POSIT_WIDTH (POSIT_WIDTH),
      .POSIT_ES    (POSIT_ES),
      .SCALE_W     (SCALE_W),
      .FRAC_W      (FRAC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load1 (load1),
      .load2 (load2),
      .posit (s_posit_i[g*POSIT_WIDTH +: POSIT_WIDTH]),
      .sign  (m_sign_o[g]),
      .nar   (m_nar_o[g]),
      .zero  (m_zero_o[g]),
      .scale (m_scale_o[g*SCALE_W +: SCALE_W]),
      .frac  (m_frac_o[g*FRAC_W +: FRAC_W])
    );
  end

`ifdef POSIT_DENORM_STATS_EN
  logic [31:0] nar_lanes, zero_lanes;

  always_comb begin
    nar_lanes  = '0;
    zero_lanes = '0;
    for (int i = 0; i < N_LANES; i++) begin
      nar_lanes  = nar_lanes  + 32'(m_nar_o[i]);
      zero_lanes = zero_lanes + 32'(m_zero_o[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats_o <= '0;
      stat_nar_o   <= '0;
      stat_zero_o  <= '0;
    end else if (m_valid_o & m_ready_i) begin
      stat_beats_o <= sat_add32(stat_beats_o, 32'd1);
      stat_nar_o   <= sat_add32(stat_nar_o, nar_lanes);
      stat_zero_o  <= sat_add32(stat_zero_o, zero_lanes);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_denormalize_pipe.sv
//==============================================================================
// Module      : tb_posit_denormalize_pipe
// Description : Random and directed stimulus against a bit-walking posit model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_posit_denormalize_pipe;

  localparam int N = 32, ES = 2, L = 4, SW = 8, FW = 27;
  localparam int SN = 8, SES = 0, SSW = 4, SFW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic             s_valid, s_ready, m_valid, m_ready;
  logic [N*L-1:0]   s_posit;
  logic [L-1:0]     m_sign, m_nar, m_zero;
  logic [L*SW-1:0]  m_scale;
  logic [L*FW-1:0]  m_frac;

  logic             sm_s_valid, sm_s_ready, sm_m_valid, sm_m_ready;
  logic [SN-1:0]    sm_s_posit;
  logic [0:0]       sm_sign, sm_nar, sm_zero;
  logic [SSW-1:0]   sm_scale;
  logic [SFW-1:0]   sm_frac;
  int               sm_idx;

`ifdef POSIT_DENORM_STATS_EN
  logic [31:0] st_beats, st_nar, st_zero;
  logic [31:0] sm_st_beats, sm_st_nar, sm_st_zero;
`endif

  posit_denormalize_pipe #(.POSIT_WIDTH(N), .POSIT_ES(ES), .N_LANES(L)) dut (
    .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_ready_o(s_ready), .s_posit_i(s_posit),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_sign_o(m_sign), .m_nar_o(m_nar),
    .m_zero_o(m_zero), .m_scale_o(m_scale), .m_frac_o(m_frac)
`ifdef POSIT_DENORM_STATS_EN
    , .stat_beats_o(st_beats), .stat_nar_o(st_nar), .stat_zero_o(st_zero)
`endif
  );

  posit_denormalize_pipe #(.POSIT_WIDTH(SN), .POSIT_ES(SES), .N_LANES(1)) dut_small (
    .clk(clk), .rst(rst), .s_valid_i(sm_s_valid), .s_ready_o(sm_s_ready), .s_posit_i(sm_s_posit),
    .m_valid_o(sm_m_valid), .m_ready_i(sm_m_ready), .m_sign_o(sm_sign), .m_nar_o(sm_nar),
    .m_zero_o(sm_zero), .m_scale_o(sm_scale), .m_frac_o(sm_frac)
`ifdef POSIT_DENORM_STATS_EN
    , .stat_beats_o(sm_st_beats), .stat_nar_o(sm_st_nar), .stat_zero_o(sm_st_zero)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walks the posit bit by bit: regime run, terminator, exponent, fraction.
  function automatic void ref_decode(input logic [63:0] w_in, input int n, input int es,
                                     output bit sg, output bit nr, output bit zr,
                                     output longint sc, output longint fr);
    logic [63:0] mask, w, u;
    int p, m, k, e, fw;
    bit r;
    mask = (64'd1 << n) - 64'd1;
    w  = w_in & mask;
    fw = n - es - 3;
    zr = (w == 0);
    nr = (w == (64'd1 << (n - 1)));
    sg = w[n-1];
    sc = 0;
    fr = 0;
    if (zr || nr) return;
    u = sg ? ((~w + 64'd1) & mask) : w;
    p = n - 2;
    r = u[p];
    m = 0;
    while (p >= 0 && u[p] == r) begin m++; p--; end
    k = r ? m - 1 : -m;
    p--;
    e = 0;
    for (int j = 0; j < es; j++) begin
      e = e * 2 + ((p >= 0) ? int'(u[p]) : 0);
      p--;
    end
    sc = longint'(k) * (64'sd1 <<< es) + e;
    if (fw > 0)
      for (int j = 0; j < fw; j++) begin
        fr = fr * 2 + ((p >= 0) ? longint'(u[p]) : 0);
        p--;
      end
  endfunction

  typedef struct { logic [N*L-1:0] w; int cyc; } beat_t;
  beat_t q[$];
  int  cyc = 0;
  bit  free_run = 1'b1;
  bit  stalled = 1'b0;
  logic [L*(3+SW+FW):0] held;
  int  delivered = 0, nar_tot = 0, zero_tot = 0;

  always @(negedge clk) begin
    beat_t b;
    bit sg, nr, zr;
    longint sc, fr;
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      cyc++;
      check("s_ready", s_ready, !(q.size() == 2 && !m_ready));
      if (stalled) begin
        checks++;
        if ({m_valid, m_sign, m_nar, m_zero, m_scale, m_frac} !== held) begin
          failures++;
          $display("FAIL stall_hold: got %h expected %h",
                   {m_valid, m_sign, m_nar, m_zero, m_scale, m_frac}, held);
        end
      end
      stalled = m_valid && !m_ready;
      held = {m_valid, m_sign, m_nar, m_zero, m_scale, m_frac};
      if (m_valid && m_ready) begin
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          b = q.pop_front();
          delivered++;
          if (free_run) check("latency", cyc - b.cyc, 2);
          for (int l = 0; l < L; l++) begin
            ref_decode(64'(b.w[l*N +: N]), N, ES, sg, nr, zr, sc, fr);
            nar_tot  += int'(nr);
            zero_tot += int'(zr);
            check($sformatf("sign[%0d] w=%h", l, b.w[l*N +: N]), m_sign[l], sg);
            check($sformatf("nar[%0d] w=%h", l, b.w[l*N +: N]), m_nar[l], nr);
            check($sformatf("zero[%0d] w=%h", l, b.w[l*N +: N]), m_zero[l], zr);
            check($sformatf("scale[%0d] w=%h", l, b.w[l*N +: N]),
                  longint'($signed(m_scale[l*SW +: SW])), sc);
            check($sformatf("frac[%0d] w=%h", l, b.w[l*N +: N]), longint'(m_frac[l*FW +: FW]), fr);
          end
        end
      end
      if (s_valid && s_ready) begin
        b.w = s_posit;
        b.cyc = cyc;
        q.push_back(b);
      end
    end
  end

  // Hand-computed N=8, ES=0 expectations.
  logic [7:0] sw_tab [8] = '{8'h40, 8'h60, 8'h50, 8'hC0, 8'h00, 8'h80, 8'h01, 8'h7F};
  int s_sg [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
  int s_nr [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int s_zr [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int s_sc [8] = '{0, 1, 0, 0, 0, 0, -6, 6};
  int s_fr [8] = '{0, 0, 16, 0, 0, 0, 0, 0};
  int sq[$], sqc[$];
  int scyc = 0, sm_got = 0;

  always @(negedge clk) begin
    int i, c;
    if (rst) begin
      sq.delete();
      sqc.delete();
    end else begin
      scyc++;
      if (sm_m_valid && sm_m_ready) begin
        if (sq.size() == 0) check("small_unexpected", 1, 0);
        else begin
          i = sq.pop_front();
          c = sqc.pop_front();
          sm_got++;
          check("small_latency", scyc - c, 2);
          check($sformatf("small_sign w=%h", sw_tab[i]), sm_sign[0], s_sg[i]);
          check($sformatf("small_nar w=%h", sw_tab[i]), sm_nar[0], s_nr[i]);
          check($sformatf("small_zero w=%h", sw_tab[i]), sm_zero[0], s_zr[i]);
          check($sformatf("small_scale w=%h", sw_tab[i]), longint'($signed(sm_scale)), s_sc[i]);
          check($sformatf("small_frac w=%h", sw_tab[i]), longint'(sm_frac), s_fr[i]);
        end
      end
      if (sm_s_valid && sm_s_ready) begin
        sq.push_back(sm_idx);
        sqc.push_back(scyc);
      end
    end
  end

  function automatic logic [N-1:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0001;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'hFFFF_FFFF;
      default: return N'($urandom());
    endcase
  endfunction

  function automatic logic [N*L-1:0] rand_beat();
    logic [N*L-1:0] v;
    for (int l = 0; l < L; l++) v[l*N +: N] = rand_word();
    return v;
  endfunction

  task automatic send_beat(input logic [N*L-1:0] w, input bit rnd_ready);
    int guard;
    bit acc;
    guard = 0;
    s_valid = 1'b1;
    s_posit = w;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sg, nr, zr;
    longint sc, fr;
    int t, base;
    s_valid = 0; s_posit = '0; m_ready = 1;
    sm_s_valid = 0; sm_s_posit = '0; sm_m_ready = 1; sm_idx = 0;

    ref_decode(64'h4000_0000, 32, 2, sg, nr, zr, sc, fr); check("model_one", sc, 0);
    ref_decode(64'h0000_0001, 32, 2, sg, nr, zr, sc, fr); check("model_minpos", sc, -120);
    ref_decode(64'h7FFF_FFFF, 32, 2, sg, nr, zr, sc, fr); check("model_maxpos", sc, 120);
    ref_decode(64'h4800_0000, 32, 2, sg, nr, zr, sc, fr); check("model_exp1", sc, 1);
    ref_decode(64'h50, 8, 0, sg, nr, zr, sc, fr);         check("model_frac", fr, 16);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_scale", longint'(m_scale[31:0]), 0);
    check("rst_flags", longint'({m_sign, m_nar, m_zero}), 0);
    check("rst_small_valid", sm_m_valid, 0);

    // N=8 directed words, back to back
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      sm_s_valid = 1'b1; sm_s_posit = sw_tab[i]; sm_idx = i;
    end
    @(posedge clk); #1 sm_s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("small_count", sm_got, 8);

    // 4-lane directed beat
    send_beat({32'h4800_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h4000_0000}, 1'b0);
    t = 0;
    do begin @(negedge clk); t++; end while (!m_valid && t < 5);
    check("dir_scale0", longint'($signed(m_scale[0*SW +: SW])), 0);
    check("dir_scale1", longint'($signed(m_scale[1*SW +: SW])), -120);
    check("dir_scale2", longint'($signed(m_scale[2*SW +: SW])), 120);
    check("dir_scale3", longint'($signed(m_scale[3*SW +: SW])), 1);
    check("dir_frac3", longint'(m_frac[3*FW +: FW]), 0);
    drain();

    // full-throughput random stream
    for (int i = 0; i < 10; i++) send_beat(rand_beat(), 1'b0);
    drain();

    // backpressure
    free_run = 1'b0;
    base = delivered;
    for (int i = 0; i < 20; i++) begin
      send_beat(rand_beat(), 1'b1);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1)); end
    end
    drain();
    check("bp_delivered", delivered - base, 20);
    free_run = 1'b1;

    // reset with two beats in flight
    send_beat(rand_beat(), 1'b0);
    send_beat(rand_beat(), 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    base = delivered;
    send_beat(rand_beat(), 1'b0);
    repeat (5) @(posedge clk);
    #1 check("post_rst_delivered", delivered - base, 1);

`ifdef POSIT_DENORM_STATS_EN
    check("stat_beats", st_beats, delivered - base);
    base = delivered;
    rst = 1'b1; #1 rst = 1'b0;
    nar_tot = 0; zero_tot = 0;
    for (int i = 0; i < 10; i++) begin
      logic [N*L-1:0] v;
      v = {4{32'h4000_0000}};
      if (i < 3) v[0 +: N] = 32'h8000_0000;
      if (i < 5) v[N +: N] = '0;
      send_beat(v, 1'b0);
    end
    drain();
    check("stat_beats10", st_beats, 10);
    check("stat_nar3", st_nar, 3);
    check("stat_zero5", st_zero, 5);
    check("stat_model_nar", nar_tot, 3);
`endif

    check("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
